fp_mul_unpack: RTL

Front-end stage of the basic FP32 multiplier. Accepts two IEEE-754 single-precision operands through a valid/ready handshake, unpacks and classifies them, and produces the biased exponent sum `Ez_add`, the 24-bit significands with hidden bit, the result sign and a special-case class. Its outputs feed the significand multiplier and, after the multiplier and LZA, the exponent-update stage. It is the producer of the `Ez_add` encoding that exponent-update consumes.

---
 rtl/fp_mul_pkg.sv | 33 +++
 rtl/fp32_classify.sv | 36 +++
 rtl/fp_mul_unpack.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fp_mul_pkg.sv
// Shared definitions for the FP32 multiplier datapath: field widths, bias and
// the result-class encoding used by the unpack and exponent-update stages.
package fp_mul_pkg;

    localparam int FP32_BIAS = 127;
    localparam int EXP_W     = 8;
    localparam int MAN_W     = 24;
    localparam int EZ_W      = 10;

    typedef enum logic [1:0] {
        CLS_NORM = 2'b00,
        CLS_ZERO = 2'b01,
        CLS_INF  = 2'b10,
        CLS_NAN  = 2'b11
    } cls_t;

    // inf * zero is invalid and therefore NaN; NaN dominates everything else.
    function automatic cls_t combine_cls(input cls_t cls_a, input cls_t cls_b);
        cls_t res;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
            (cls_a == CLS_INF && cls_b == CLS_ZERO) ||
            (cls_a == CLS_ZERO && cls_b == CLS_INF))
            res = CLS_NAN;
        else if (cls_a == CLS_INF || cls_b == CLS_INF)
            res = CLS_INF;
        else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO)
            res = CLS_ZERO;
        else
            res = CLS_NORM;
        return res;
    endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational unpack of one FP32 operand into sign, biased exponent,
// significand with hidden bit, and operand class.
module fp32_classify
    import fp_mul_pkg::*;
#(
    parameter int FTZ = 1
) (
    input  logic [31:0]      x,
    output cls_t             cls,
    output logic             sign,
    output logic [EXP_W-1:0] exp,
    output logic [MAN_W-1:0] man
);

    logic [EXP_W-1:0] exp_f;
    logic [22:0]      frac;

    assign exp_f = x[30:23];
    assign frac  = x[22:0];
    assign sign  = x[31];
    assign exp   = exp_f;

    always_comb begin
        cls = CLS_NORM;
        man = {1'b1, frac};
        if (exp_f == '0) begin
            cls = CLS_ZERO;
            // Subnormals are classed as zero; only the flushed significand is meaningful.
            man = (FTZ != 0) ? '0 : {1'b0, frac};
        end else if (exp_f == '1) begin
            cls = (frac == '0) ? CLS_INF : CLS_NAN;
            man = '0;
        end
    end

endmodule

// File: rtl/fp_mul_unpack.sv
// FP32 multiplier front end: two-stage valid/ready pipeline that unpacks and
// classifies both operands and forms the biased exponent sum Ez_add.
module fp_mul_unpack
    import fp_mul_pkg::*;
#(
    parameter int BIAS = FP32_BIAS,
    parameter int FTZ  = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       A,
    input  logic [31:0]       B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EZ_W-1:0]   Ez_add,
    output logic [MAN_W-1:0]  Ma,
    output logic [MAN_W-1:0]  Mb,
    output logic              Sz,
    output logic [1:0]        cls
);

    cls_t             cls_a_c, cls_b_c;
    logic             sign_a_c, sign_b_c;
    logic [EXP_W-1:0] exp_a_c, exp_b_c;
    logic [MAN_W-1:0] man_a_c, man_b_c;

    fp32_classify #(.FTZ(FTZ)) u_cls_a (
        .x    (A),
        .cls  (cls_a_c),
        .sign (sign_a_c),
        .exp  (exp_a_c),
        .man  (man_a_c)
    );

    fp32_classify #(.FTZ(FTZ)) u_cls_b (
        .x    (B),
        .cls  (cls_b_c),
        .sign (sign_b_c),
        .exp  (exp_b_c),
        .man  (man_b_c)
    );

    logic             s1_valid, s2_valid;
    logic             s1_ready, s2_ready;
    cls_t             s1_cls_a, s1_cls_b;
    logic             s1_sz;
    logic [EXP_W-1:0] s1_ea, s1_eb;
    logic [MAN_W-1:0] s1_ma, s1_mb;

    cls_t             s2_cls;
    logic             s2_sz;
    logic [EZ_W-1:0]  s2_ez;
    logic [MAN_W-1:0] s2_ma, s2_mb;

    cls_t             res_cls;
    logic [EZ_W-1:0]  ez_sum;

    assign s2_ready = !s2_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready;

    always_comb begin
        res_cls = combine_cls(s1_cls_a, s1_cls_b);
        // 10-bit two's complement; normal operands span -125..381 so it never wraps.
        ez_sum  = {2'b00, s1_ea} + {2'b00, s1_eb} - EZ_W'(BIAS);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            s1_valid <= 1'b0;
            s1_cls_a <= CLS_NORM;
            s1_cls_b <= CLS_NORM;
            s1_sz    <= 1'b0;
            s1_ea    <= '0;
            s1_eb    <= '0;
            s1_ma    <= '0;
            s1_mb    <= '0;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_cls_a <= cls_a_c;
                s1_cls_b <= cls_b_c;
                s1_sz    <= sign_a_c ^ sign_b_c;
                s1_ea    <= exp_a_c;
                s1_eb    <= exp_b_c;
                s1_ma    <= man_a_c;
                s1_mb    <= man_b_c;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            s2_valid <= 1'b0;
            s2_cls   <= CLS_NORM;
            s2_sz    <= 1'b0;
            s2_ez    <= '0;
            s2_ma    <= '0;
            s2_mb    <= '0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_cls <= res_cls;
                s2_sz  <= s1_sz;
                if (res_cls == CLS_NORM) begin
                    s2_ez <= ez_sum;
                    s2_ma <= s1_ma;
                    s2_mb <= s1_mb;
                end else begin
                    s2_ez <= '0;
                    s2_ma <= '0;
                    s2_mb <= '0;
                end
            end
        end
    end

    assign out_valid = s2_valid;
    assign Ez_add    = s2_ez;
    assign Ma        = s2_ma;
    assign Mb        = s2_mb;
    assign Sz        = s2_sz;
    assign cls       = s2_cls;

endmodule
